// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch/branch constants and fetch FSM encoding
package fetch_unit_pkg;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 16;
  localparam int PC_BYTE_STEP = 1;
  localparam int PC_INSTR_STEP = 2;
  typedef enum logic [2:0] {
    ISSUE_HI = 3'd0,
    CAP_HI   = 3'd1,
    CAP_LO   = 3'd2,
    EXEC     = 3'd3,
    HALTED   = 3'd4
  } state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner assembling 16-bit big-endian instructions from two byte reads, en-gated
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [ADDR_W-1:0]  effAddr,
  input  logic               halt,
  input  logic [7:0]         memData,
  output logic [ADDR_W-1:0]  memAddr,
  output logic               memRd,
  output logic [ADDR_W-1:0]  currAddr,
  output logic [INSTR_W-1:0] instr,
  output logic               instrValid,
  output logic               halted,
  output logic [CNT_W-1:0]   retireCount
);
  state_t state, state_n;
  logic [ADDR_W-1:0] pc;
  logic [INSTR_W-1:0] instr_r;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) state <= ISSUE_HI;
    else state <= state_n;
  end
  always_comb begin
    state_n = !en ? state :
              state == ISSUE_HI ? CAP_HI :
              state == CAP_HI ? CAP_LO :
              state == CAP_LO ? EXEC :
              state == EXEC ? (halt ? HALTED : ISSUE_HI) : HALTED;
    memAddr = state == CAP_HI ? pc + ADDR_W'(PC_BYTE_STEP) : pc;
    memRd = en && (state == ISSUE_HI || state == CAP_HI);
    instrValid = state == EXEC;
    halted = state == HALTED;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      instr_r <= '0;
      cnt <= '0;
    end else if (en) begin
      if (state == CAP_HI) instr_r[INSTR_W-1 -: 8] <= memData;
      if (state == CAP_LO) instr_r[7:0] <= memData;
      if (state == EXEC) begin
        pc <= effAddr;
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign currAddr = pc;
  assign instr = instr_r;
  assign retireCount = cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a registered-read byte memory model
module tb_fetch_unit;
  logic clk = 0, rst = 1, en = 0, halt = 0, memRd, instrValid, halted;
  logic [7:0] effAddr = 0, memData = 0, memAddr, currAddr;
  logic [15:0] instr, retireCount;
  logic [7:0] mem [256];
  logic [39:0] exp_q [$];
  logic [7:0] rd_q [$];
  int n_cmp = 0, n_bad = 0;
  fetch_unit dut (
    .clk(clk), .rst(rst), .en(en), .effAddr(effAddr), .halt(halt), .memData(memData),
    .memAddr(memAddr), .memRd(memRd), .currAddr(currAddr), .instr(instr),
    .instrValid(instrValid), .halted(halted), .retireCount(retireCount)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (memRd) memData <= mem[memAddr];
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (!en) cmp("memrd_idle", memRd, 0);
      if (memRd) begin
        if (rd_q.size() == 0) cmp("rd_unexpected", memAddr, 32'hFFFF_FFFF);
        else cmp("rd_addr", memAddr, rd_q.pop_front());
      end
      if (instrValid && en) begin
        if (exp_q.size() == 0) cmp("exec_unexpected", currAddr, 32'hFFFF_FFFF);
        else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          cmp("curr_addr", currAddr, e[39:32]);
          cmp("instr", instr, e[31:16]);
          cmp("retire_cnt", retireCount, e[15:0]);
        end
      end
    end
  end
  task automatic run(input int per, input logic [7:0] a, input logic [15:0] ins,
                     input logic [15:0] c, input logic [7:0] nxt, input logic h);
    int n = 0;
    bit done = 0;
    exp_q.push_back({a, ins, c});
    rd_q.push_back(a);
    rd_q.push_back(a + 8'd1);
    effAddr = nxt;
    halt = h;
    while (!done && n < 4 * per + 8) begin
      n++;
      en = (n % per == 0);
      @(negedge clk);
      done = instrValid && en;
      @(posedge clk);
      #1;
    end
    cmp("latency", n, 4 * per);
    en = 0;
    halt = 0;
  endtask
  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) begin
      en = 1;
      @(posedge clk);
      #1;
    end
    en = 0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h12;
    mem[1] = 8'h34;
    mem[2] = 8'h56;
    mem[3] = 8'h78;
    en = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    cmp("rst_valid", instrValid, 0);
    cmp("rst_halted", halted, 0);
    cmp("rst_addr", currAddr, 0);
    cmp("rst_instr", instr, 0);
    cmp("rst_cnt", retireCount, 0);
    cmp("rst_memaddr", memAddr, 0);
    cmp("rst_memrd", memRd, 1);
    @(posedge clk);
    #1;
    rst = 0;
    en = 0;
    run(1, 8'h00, 16'h1234, 16'd0, 8'h02, 0);
    run(1, 8'h02, 16'h5678, 16'd1, 8'h04, 0);
    run(1, 8'h04, 16'hA1A0, 16'd2, 8'h40, 0);
    run(1, 8'h40, 16'hE5E4, 16'd3, 8'hFE, 0);
    run(1, 8'hFE, 16'h5B5A, 16'd4, 8'h00, 0);
    run(1, 8'h00, 16'h1234, 16'd5, 8'hFF, 0);
    run(1, 8'hFF, 16'h5A12, 16'd6, 8'h02, 0);
    run(3, 8'h02, 16'h5678, 16'd7, 8'h04, 0);
    run(3, 8'h04, 16'hA1A0, 16'd8, 8'h10, 1);
    for (int i = 0; i < 20; i++) begin
      en = 1;
      @(posedge clk);
      #1;
    end
    en = 0;
    @(negedge clk);
    cmp("halted", halted, 1);
    cmp("halt_valid", instrValid, 0);
    cmp("halt_pc", currAddr, 8'h10);
    cmp("halt_cnt", retireCount, 16'd9);
    cmp("halt_instr", instr, 16'hA1A0);
    @(posedge clk);
    #1;
    rst = 1;
    en = 1;
    @(posedge clk);
    #1;
    rst = 0;
    en = 0;
    @(negedge clk);
    cmp("unhalt", halted, 0);
    @(posedge clk);
    #1;
    rd_q.push_back(8'h00);
    rd_q.push_back(8'h01);
    ticks(2);
    rst = 1;
    en = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    cmp("abort_pc", currAddr, 0);
    cmp("abort_cnt", retireCount, 0);
    cmp("abort_valid", instrValid, 0);
    @(posedge clk);
    #1;
    rst = 0;
    en = 0;
    run(1, 8'h00, 16'h1234, 16'd0, 8'h02, 0);
    @(negedge clk);
    cmp("exp_q_empty", exp_q.size(), 0);
    cmp("rd_q_empty", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
